// File: rtl/sec_lowest.sv
// Purpose: running second-lowest distinct value of a valid-qualified stream; SEC_LOWEST_STATUS_EN adds lowest/second_valid.
// Latency: 1 cycle, the accepted sample is reflected right after its edge.
// Backpressure: none; every sample with valid=1 is consumed.
module sec_lowest #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
`ifdef SEC_LOWEST_STATUS_EN
    output logic [WIDTH-1:0] lowest,
    output logic             second_valid,
`endif
    output logic [WIDTH-1:0] second_lowest
);

    // Fill level: how many distinct values have been captured so far (max 2).
    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_TWO   = 2'd2
    } fill_t;

    fill_t            fill_q,   fill_nxt;
    logic [WIDTH-1:0] lowest_q, lowest_nxt;
    logic [WIDTH-1:0] second_q, second_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q   <= FILL_EMPTY;
            lowest_q <= '1;
            second_q <= '1;
        end else begin
            fill_q   <= fill_nxt;
            lowest_q <= lowest_nxt;
            second_q <= second_nxt;
        end
    end

    always_comb begin
        fill_nxt   = fill_q;
        lowest_nxt = lowest_q;
        second_nxt = second_q;
        if (valid) begin
            unique case (fill_q)
                FILL_EMPTY: begin
                    lowest_nxt = data;
                    fill_nxt   = FILL_ONE;
                end
                FILL_ONE: begin
                    if (data < lowest_q) begin
                        second_nxt = lowest_q;
                        lowest_nxt = data;
                        fill_nxt   = FILL_TWO;
                    end else if (data > lowest_q) begin
                        second_nxt = data;
                        fill_nxt   = FILL_TWO;
                    end
                end
                FILL_TWO: begin
                    // Values equal to either tracked entry are duplicates and ignored.
                    if (data < lowest_q) begin
                        second_nxt = lowest_q;
                        lowest_nxt = data;
                    end else if ((data > lowest_q) && (data < second_q)) begin
                        second_nxt = data;
                    end
                end
                default: begin
                    fill_nxt = FILL_EMPTY;
                end
            endcase
        end
    end

    assign second_lowest = second_q;

`ifdef SEC_LOWEST_STATUS_EN
    assign lowest       = lowest_q;
    assign second_valid = (fill_q == FILL_TWO);
`endif

endmodule

// File: tb/tb_sec_lowest.sv
// Scoreboarded bench for sec_lowest: a sorted distinct-value model predicts each cycle's outputs.
module tb_sec_lowest;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] second_lowest;
`ifdef SEC_LOWEST_STATUS_EN
    logic [WIDTH-1:0] lowest;
    logic             second_valid;
`endif

    sec_lowest #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid         (valid),
        .data          (data),
`ifdef SEC_LOWEST_STATUS_EN
        .lowest        (lowest),
        .second_valid  (second_valid),
`endif
        .second_lowest (second_lowest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sec;
        logic [WIDTH-1:0] low;
        logic             sv;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] seen[$];
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Reference: set of distinct accepted values since reset.
    function automatic void model_add(input logic [WIDTH-1:0] d);
        foreach (seen[i]) if (seen[i] == d) return;
        seen.push_back(d);
    endfunction

    function automatic exp_t model_out();
        exp_t             e;
        logic [WIDTH-1:0] tmp[$];
        tmp = seen;
        tmp.sort();
        e.sec = (tmp.size() >= 2) ? tmp[1] : {WIDTH{1'b1}};
        e.low = (tmp.size() >= 1) ? tmp[0] : {WIDTH{1'b1}};
        e.sv  = (tmp.size() >= 2);
        return e;
    endfunction

    task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] d);
        exp_t e;
        @(negedge clk);
        rst   = r;
        valid = v;
        data  = d;
        if (r) seen.delete();
        else if (v) model_add(d);
        e = model_out();
        @(posedge clk);
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per clock, compared mid-cycle.
    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("second_lowest", 32'(second_lowest), 32'(mon_e.sec));
`ifdef SEC_LOWEST_STATUS_EN
            check("lowest", 32'(lowest), 32'(mon_e.low));
            check("second_valid", 32'(second_valid), 32'(mon_e.sv));
`endif
        end
    end

    function automatic logic [WIDTH-1:0] rand_data();
        case ($urandom_range(0, 3))
            0:       return WIDTH'($urandom_range(0, 15));
            1:       return WIDTH'($urandom);
            2:       return ($urandom_range(0, 1) != 0) ? {WIDTH{1'b1}} : '0;
            default: return WIDTH'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        data  = '0;

        repeat (4) step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'd10);
        step(1'b0, 1'b1, 16'd3);
        step(1'b0, 1'b1, 16'd7);
        step(1'b0, 1'b1, 16'd20);

        step(1'b1, 1'b0, 16'h0000);
        repeat (3) step(1'b0, 1'b1, 16'd8);
        step(1'b0, 1'b1, 16'd2);

        step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b1, 16'hFFFF);
        step(1'b0, 1'b1, 16'h0001);

        step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'd50);
        step(1'b0, 1'b1, 16'd40);
        repeat (3) step(1'b0, 1'b0, 16'd1);

        step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'd9);
        step(1'b0, 1'b1, 16'd4);
        step(1'b1, 1'b1, 16'd1);
        step(1'b0, 1'b1, 16'd6);
        step(1'b0, 1'b1, 16'd5);

        for (int run = 0; run < 100; run++) begin
            step(1'b1, 1'b0, WIDTH'($urandom));
            for (int k = 0; k < 10; k++)
                step(1'b0, ($urandom_range(0, 7) != 0), rand_data());
        end

        step(1'b0, 1'b0, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
